// File: rtl/vram32_arbiter.sv
// Single-port VRAM32 arbiter for the BGW renderer, sprite renderer and CPU.
// Grants are combinational; read data returns one cycle later tagged by owner.
module vram32_arbiter #(
   parameter int ADDR_W       = 14,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              i_vga_clk,
   input  logic              i_reset,
   input  logic              i_bgw_req,
   input  logic [ADDR_W-1:0] i_bgw_addr,
   output logic              o_bgw_gnt,
   output logic              o_bgw_valid,
   input  logic              i_spr_req,
   input  logic [ADDR_W-1:0] i_spr_addr,
   output logic              o_spr_gnt,
   output logic              o_spr_valid,
   input  logic              i_cpu_req,
   input  logic              i_cpu_we,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic              o_cpu_gnt,
   output logic              o_cpu_valid,
   output logic [DATA_W-1:0] o_rd_q,
   output logic [ADDR_W-1:0] o_vram32_addr,
   output logic [DATA_W-1:0] o_vram32_d,
   output logic              o_vram32_we,
   input  logic [DATA_W-1:0] i_vram32_q
);

   localparam logic [1:0] TAG_NONE = 2'd0;
   localparam logic [1:0] TAG_BGW  = 2'd1;
   localparam logic [1:0] TAG_SPR  = 2'd2;
   localparam logic [1:0] TAG_CPU  = 2'd3;
   localparam logic [7:0] LIMIT    = 8'(STARVE_LIMIT);

   logic [7:0]        r_starve_cnt;
   logic [1:0]        r_tag;
   logic [ADDR_W-1:0] r_addr;
   logic              w_boost;
   logic              w_bgw_gnt;
   logic              w_spr_gnt;
   logic              w_cpu_gnt;
   logic [ADDR_W-1:0] w_addr;
   logic [1:0]        w_tag_nxt;

   assign w_boost = (r_starve_cnt == LIMIT);

   // Grant selection: BGW always first; a starved CPU overtakes the sprite unit.
   always_comb begin
      w_bgw_gnt = 1'b0;
      w_spr_gnt = 1'b0;
      w_cpu_gnt = 1'b0;
      if (i_reset) begin
         w_bgw_gnt = 1'b0;
      end else if (i_bgw_req) begin
         w_bgw_gnt = 1'b1;
      end else if (w_boost) begin
         if (i_cpu_req) begin
            w_cpu_gnt = 1'b1;
         end else begin
            w_spr_gnt = i_spr_req;
         end
      end else begin
         if (i_spr_req) begin
            w_spr_gnt = 1'b1;
         end else begin
            w_cpu_gnt = i_cpu_req;
         end
      end
   end

   // Address and read-tag for the winner; idle cycles keep the last address.
   always_comb begin
      w_addr    = r_addr;
      w_tag_nxt = TAG_NONE;
      if (w_bgw_gnt) begin
         w_addr    = i_bgw_addr;
         w_tag_nxt = TAG_BGW;
      end else if (w_spr_gnt) begin
         w_addr    = i_spr_addr;
         w_tag_nxt = TAG_SPR;
      end else if (w_cpu_gnt) begin
         w_addr    = i_cpu_addr;
         w_tag_nxt = i_cpu_we ? TAG_NONE : TAG_CPU;
      end else begin
         w_addr    = r_addr;
         w_tag_nxt = TAG_NONE;
      end
   end

   // Starvation counter, held address and read-owner tag.
   always_ff @(posedge i_vga_clk) begin
      if (i_reset) begin
         r_starve_cnt <= 8'd0;
         r_tag        <= TAG_NONE;
         r_addr       <= '0;
      end else begin
         if (i_cpu_req && !w_cpu_gnt) begin
            r_starve_cnt <= w_boost ? r_starve_cnt : r_starve_cnt + 8'd1;
         end else begin
            r_starve_cnt <= 8'd0;
         end
         r_tag  <= w_tag_nxt;
         r_addr <= w_addr;
      end
   end

   // Valids are masked by reset so a read granted just before reset is dropped.
   assign o_bgw_valid   = (r_tag == TAG_BGW) && !i_reset;
   assign o_spr_valid   = (r_tag == TAG_SPR) && !i_reset;
   assign o_cpu_valid   = (r_tag == TAG_CPU) && !i_reset;
   assign o_rd_q        = i_vram32_q;
   assign o_bgw_gnt     = w_bgw_gnt;
   assign o_spr_gnt     = w_spr_gnt;
   assign o_cpu_gnt     = w_cpu_gnt;
   assign o_vram32_addr = w_addr;
   assign o_vram32_we   = w_cpu_gnt && i_cpu_we;
   assign o_vram32_d    = i_cpu_wdata;

endmodule

// File: tb/tb_vram32_arbiter.sv
// Bench for vram32_arbiter: directed literal checks plus random traffic
// compared every cycle against a priority/queue model and a shadow memory.
module tb_vram32_arbiter;

   localparam int AW    = 14;
   localparam int DW    = 32;
   localparam int LIMIT = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          bgw_req, spr_req, cpu_req, cpu_we;
   logic [AW-1:0] bgw_addr, spr_addr, cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          bgw_gnt, bgw_valid, spr_gnt, spr_valid, cpu_gnt, cpu_valid;
   logic [DW-1:0] rd_q, vram_d, vram_q;
   logic [AW-1:0] vram_addr;
   logic          vram_we;

   int total = 0;
   int bad   = 0;

   // environment RAM (drives the DUT) and shadow copy (expected contents)
   logic [DW-1:0] ram    [0:(1<<AW)-1];
   logic [DW-1:0] shadow [0:(1<<AW)-1];

   // model state
   int            m_starve   = 0;
   int            m_pend     = 0;     // 0 none, 1 bgw, 2 spr, 3 cpu
   logic [DW-1:0] m_pend_data = '0;
   logic [AW-1:0] m_addr     = '0;
   int            last_win   = 0;

   always #5 clk = ~clk;

   vram32_arbiter dut (
      .i_vga_clk(clk), .i_reset(reset),
      .i_bgw_req(bgw_req), .i_bgw_addr(bgw_addr), .o_bgw_gnt(bgw_gnt), .o_bgw_valid(bgw_valid),
      .i_spr_req(spr_req), .i_spr_addr(spr_addr), .o_spr_gnt(spr_gnt), .o_spr_valid(spr_valid),
      .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
      .o_cpu_gnt(cpu_gnt), .o_cpu_valid(cpu_valid), .o_rd_q(rd_q),
      .o_vram32_addr(vram_addr), .o_vram32_d(vram_d), .o_vram32_we(vram_we), .i_vram32_q(vram_q)
   );

   always @(posedge clk) begin
      if (vram_we) ram[vram_addr] <= vram_d;
      vram_q <= ram[vram_addr];
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // per-cycle reference check at the falling edge, then advance the model
   always @(negedge clk) begin
      int            win;
      logic [AW-1:0] ea;
      logic [2:0]    eg, ev;
      win = 0;
      if (!reset) begin
         if (bgw_req) win = 1;
         else if (m_starve == LIMIT) win = cpu_req ? 3 : (spr_req ? 2 : 0);
         else win = spr_req ? 2 : (cpu_req ? 3 : 0);
      end
      ea = (win == 1) ? bgw_addr : (win == 2) ? spr_addr : (win == 3) ? cpu_addr : m_addr;
      eg = (win == 0) ? 3'b000 : 3'(1 << (win - 1));
      ev = (reset || m_pend == 0) ? 3'b000 : 3'(1 << (m_pend - 1));
      chk("gnt", DW'({cpu_gnt, spr_gnt, bgw_gnt}), DW'(eg));
      chk("valid", DW'({cpu_valid, spr_valid, bgw_valid}), DW'(ev));
      if (ev != 3'b000) chk("rd_q", rd_q, m_pend_data);
      chk("we", DW'(vram_we), DW'(win == 3 && cpu_we));
      chk("addr", DW'(vram_addr), DW'(ea));
      chk("wdata", vram_d, cpu_wdata);
      last_win = win;
      if (reset) begin
         m_starve = 0;
         m_pend   = 0;
         m_addr   = '0;
      end else begin
         m_starve = (cpu_req && win != 3) ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
         m_pend   = (win == 3 && cpu_we) ? 0 : win;
         m_pend_data = shadow[ea];
         m_addr   = ea;
         if (win == 3 && cpu_we) shadow[cpu_addr] = cpu_wdata;
      end
   end

   task automatic drive(input logic rst, input logic b, input logic [AW-1:0] ba,
                        input logic s, input logic [AW-1:0] sa,
                        input logic c, input logic w, input logic [AW-1:0] ca,
                        input logic [DW-1:0] wd);
      @(posedge clk);
      #1;
      reset = rst; bgw_req = b; bgw_addr = ba; spr_req = s; spr_addr = sa;
      cpu_req = c; cpu_we = w; cpu_addr = ca; cpu_wdata = wd;
      #3;
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) begin
         ram[i]    = $urandom;
         shadow[i] = ram[i];
      end
      ram[16]    = 32'hDEAD_BEEF;
      shadow[16] = 32'hDEAD_BEEF;
      reset = 1'b1; bgw_req = 1'b0; spr_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
      bgw_addr = '0; spr_addr = '0; cpu_addr = '0; cpu_wdata = '0;
      drive(1'b1, 1'b0, 14'h0, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 32'h0);

      // BGW read of a preloaded word
      drive(1'b0, 1'b1, 14'h0010, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 32'h0);
      chk("d_bgw_gnt", DW'(bgw_gnt), 32'd1);
      chk("d_bgw_addr", DW'(vram_addr), 32'h10);
      drive(1'b0, 1'b0, 14'h0, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 32'h0);
      chk("d_bgw_valid", DW'(bgw_valid), 32'd1);
      chk("d_bgw_data", rd_q, 32'hDEAD_BEEF);

      // all three request; BGW leaves after one grant; CPU starves to the limit
      drive(1'b0, 1'b1, 14'h1, 1'b1, 14'h2, 1'b1, 1'b0, 14'h3, 32'h0);
      chk("d_three_c1", DW'({cpu_gnt, spr_gnt, bgw_gnt}), 32'b001);
      for (int i = 2; i <= 8; i++) begin
         drive(1'b0, 1'b0, 14'h0, 1'b1, 14'h2, 1'b1, 1'b0, 14'h3, 32'h0);
         chk("d_three_spr", DW'({cpu_gnt, spr_gnt, bgw_gnt}), 32'b010);
      end
      drive(1'b0, 1'b0, 14'h0, 1'b1, 14'h2, 1'b1, 1'b0, 14'h3, 32'h0);
      chk("d_three_cpu", DW'({cpu_gnt, spr_gnt, bgw_gnt}), 32'b100);
      drive(1'b0, 1'b0, 14'h0, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 32'h0);

      // SPR and CPU held: eight sprite grants, CPU on the ninth, counter cleared
      for (int i = 1; i <= 8; i++) begin
         drive(1'b0, 1'b0, 14'h0, 1'b1, 14'h5, 1'b1, 1'b0, 14'h6, 32'h0);
         chk("d_starve_spr", DW'({cpu_gnt, spr_gnt, bgw_gnt}), 32'b010);
      end
      drive(1'b0, 1'b0, 14'h0, 1'b1, 14'h5, 1'b1, 1'b0, 14'h6, 32'h0);
      chk("d_starve_cpu", DW'({cpu_gnt, spr_gnt, bgw_gnt}), 32'b100);
      drive(1'b0, 1'b0, 14'h0, 1'b1, 14'h5, 1'b1, 1'b0, 14'h6, 32'h0);
      chk("d_starve_clr", DW'({cpu_gnt, spr_gnt, bgw_gnt}), 32'b010);
      drive(1'b0, 1'b0, 14'h0, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 32'h0);

      // CPU write then read-back
      drive(1'b0, 1'b0, 14'h0, 1'b0, 14'h0, 1'b1, 1'b1, 14'h0100, 32'h1234_5678);
      chk("d_wr_we", DW'(vram_we), 32'd1);
      chk("d_wr_addr", DW'(vram_addr), 32'h100);
      drive(1'b0, 1'b0, 14'h0, 1'b0, 14'h0, 1'b1, 1'b0, 14'h0100, 32'h0);
      chk("d_rd_we", DW'(vram_we), 32'd0);
      chk("d_wr_novalid", DW'(cpu_valid), 32'd0);
      drive(1'b0, 1'b0, 14'h0, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 32'h0);
      chk("d_rd_valid", DW'(cpu_valid), 32'd1);
      chk("d_rd_data", rd_q, 32'h1234_5678);

      // reset right after a sprite grant
      drive(1'b0, 1'b0, 14'h0, 1'b1, 14'h5, 1'b0, 1'b0, 14'h0, 32'h0);
      chk("d_rst_gnt", DW'(spr_gnt), 32'd1);
      drive(1'b1, 1'b1, 14'h9, 1'b1, 14'h5, 1'b1, 1'b1, 14'h9, 32'h0);
      chk("d_rst_valid", DW'(spr_valid), 32'd0);
      chk("d_rst_gnts", DW'({cpu_gnt, spr_gnt, bgw_gnt, vram_we}), 32'd0);
      drive(1'b0, 1'b0, 14'h0, 1'b1, 14'h7, 1'b0, 1'b0, 14'h0, 32'h0);
      chk("d_post_gnt", DW'(spr_gnt), 32'd1);
      chk("d_post_valid", DW'(spr_valid), 32'd0);
      drive(1'b0, 1'b0, 14'h0, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 32'h0);
      chk("d_post_valid2", DW'(spr_valid), 32'd1);

      // random traffic; requesters hold until granted
      for (int n = 0; n < 10000; n++) begin
         logic          b, s, c, w, r;
         logic [AW-1:0] ba, sa, ca;
         logic [DW-1:0] wd;
         b = bgw_req; ba = bgw_addr; s = spr_req; sa = spr_addr;
         c = cpu_req; w = cpu_we; ca = cpu_addr; wd = cpu_wdata;
         if (!(b && last_win != 1)) begin
            b = ($urandom_range(0, 9) < 3); ba = AW'($urandom_range(0, 63));
         end
         if (!(s && last_win != 2)) begin
            s = ($urandom_range(0, 9) < 5); sa = AW'($urandom_range(0, 63));
         end
         if (!(c && last_win != 3)) begin
            c = ($urandom_range(0, 9) < 5); w = $urandom_range(0, 1) == 1;
            ca = AW'($urandom_range(0, 63)); wd = $urandom;
         end
         r = ($urandom_range(0, 199) == 0);
         drive(r, b, ba, s, sa, c, w, ca, wd);
      end
      drive(1'b0, 1'b0, 14'h0, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0, 32'h0);
      @(posedge clk);
      #6;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
